// File: rtl/r8_pkg.sv
// Constants shared by the radius-8 column feeder and the patch-sum stage.
package r8_pkg;

    localparam int unsigned R8_RADIUS = 8;
    localparam int unsigned R8_TAPS   = 2 * R8_RADIUS + 1;
    localparam int unsigned PIX_W     = 8;
    localparam int unsigned R8_SUM_W  = 17;
    localparam int unsigned R8_NUM_LB = R8_TAPS - 1;

    typedef logic [PIX_W-1:0] pix_t;

endpackage

// File: rtl/r8_column_feeder_if.sv
// Pixel-in / column-out bundle of the radius-8 column feeder.
interface r8_column_feeder_if;
    import r8_pkg::*;

    logic done_i;
    pix_t data_i;
    pix_t S1, S2, S3, S4, S5, S6, S7, S8, S9;
    pix_t S10, S11, S12, S13, S14, S15, S16, S17;
    logic done_o;
    logic progress_done_o;

    modport slave (
        input  done_i, data_i,
        output S1, S2, S3, S4, S5, S6, S7, S8, S9,
        output S10, S11, S12, S13, S14, S15, S16, S17,
        output done_o, progress_done_o
    );

    modport master (
        output done_i, data_i,
        input  S1, S2, S3, S4, S5, S6, S7, S8, S9,
        input  S10, S11, S12, S13, S14, S15, S16, S17,
        input  done_o, progress_done_o
    );

endinterface

// File: rtl/r8_line_buffer.sv
// One image row of delay: q is d delayed by DEPTH enabled clock edges.
module r8_line_buffer #(
    parameter int unsigned DEPTH = 19,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d    = mem_q;
        mem_d[0] = d;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i-1];
        end
    end

    // Contents survive reset; shifting is only frozen while rst is held.
    always_ff @(posedge clk) begin
        if (en && !rst) begin
            mem_q <= mem_d;
        end
    end

    assign q = mem_q[DEPTH-1];

endmodule

// File: rtl/r8_column_feeder.sv
// Buffers 16 rows of a raster stream and emits 17 vertically aligned samples
// per pixel column once row 16 of the frame is reached.
module r8_column_feeder
    import r8_pkg::*;
#(
    parameter int unsigned COLS = 19,
    parameter int unsigned ROWS = 19
) (
    input logic               clk,
    input logic               rst,
    r8_column_feeder_if.slave bus
);

    localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW-1:0] EMIT_ROW = RW'(R8_NUM_LB);

    if (ROWS < R8_TAPS) begin : g_rows_chk
        $error("r8_column_feeder: ROWS must be at least %0d", R8_TAPS);
    end

    pix_t lb_q [R8_NUM_LB];
    pix_t tap  [R8_TAPS];

    // Chain index i holds line buffer LB(i+1); the newest row enters the top.
    for (genvar i = 0; i < R8_NUM_LB; i++) begin : g_lb
        pix_t lb_d;
        if (i == R8_NUM_LB - 1) begin : g_head
            assign lb_d = bus.data_i;
        end else begin : g_link
            assign lb_d = lb_q[i+1];
        end

        r8_line_buffer #(
            .DEPTH (COLS),
            .W     (PIX_W)
        ) u_lb (
            .clk (clk),
            .rst (rst),
            .en  (bus.done_i),
            .d   (lb_d),
            .q   (lb_q[i])
        );
    end

    always_comb begin
        for (int unsigned k = 0; k < R8_NUM_LB; k++) begin
            tap[k] = lb_q[k];
        end
        tap[R8_TAPS-1] = bus.data_i;
    end

    logic [CW-1:0] col_cnt_q, col_cnt_d;
    logic [RW-1:0] row_cnt_q, row_cnt_d;
    pix_t          s_q [R8_TAPS];
    pix_t          s_d [R8_TAPS];
    logic          done_q, done_d;
    logic          prog_q, prog_d;

    always_comb begin
        col_cnt_d = col_cnt_q;
        row_cnt_d = row_cnt_q;
        s_d       = s_q;
        done_d    = 1'b0;
        prog_d    = 1'b0;
        if (bus.done_i) begin
            if (row_cnt_q >= EMIT_ROW) begin
                s_d    = tap;
                done_d = 1'b1;
            end
            if (col_cnt_q == COL_LAST) begin
                col_cnt_d = '0;
                if (row_cnt_q == ROW_LAST) begin
                    row_cnt_d = '0;
                    prog_d    = 1'b1;
                end else begin
                    row_cnt_d = row_cnt_q + 1'b1;
                end
            end else begin
                col_cnt_d = col_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt_q <= '0;
            row_cnt_q <= '0;
            s_q       <= '{default: '0};
            done_q    <= 1'b0;
            prog_q    <= 1'b0;
        end else begin
            col_cnt_q <= col_cnt_d;
            row_cnt_q <= row_cnt_d;
            s_q       <= s_d;
            done_q    <= done_d;
            prog_q    <= prog_d;
        end
    end

    assign bus.S1  = s_q[0];
    assign bus.S2  = s_q[1];
    assign bus.S3  = s_q[2];
    assign bus.S4  = s_q[3];
    assign bus.S5  = s_q[4];
    assign bus.S6  = s_q[5];
    assign bus.S7  = s_q[6];
    assign bus.S8  = s_q[7];
    assign bus.S9  = s_q[8];
    assign bus.S10 = s_q[9];
    assign bus.S11 = s_q[10];
    assign bus.S12 = s_q[11];
    assign bus.S13 = s_q[12];
    assign bus.S14 = s_q[13];
    assign bus.S15 = s_q[14];
    assign bus.S16 = s_q[15];
    assign bus.S17 = s_q[16];

    assign bus.done_o          = done_q;
    assign bus.progress_done_o = prog_q;

endmodule

// File: tb/tb_r8_column_feeder.sv
// Bench for r8_column_feeder: pixel history model predicts every output cycle.
module tb_r8_column_feeder;

    localparam int unsigned COLS = 19;
    localparam int unsigned ROWS = 19;
    localparam int unsigned NPIX = COLS * ROWS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    r8_column_feeder_if bus ();

    r8_column_feeder #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned chk_cnt  = 0;
    int unsigned pass_cnt = 0;

    task automatic check_eq(input string tag, input logic [135:0] got, input logic [135:0] exp);
        chk_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Model: every accepted pixel of the current frame, indexed by raster position.
    logic [7:0]   hist [NPIX];
    int unsigned  n;
    logic [135:0] exp_s;
    logic         exp_done, exp_prog;

    int unsigned  strobes;
    int unsigned  prog_at;
    int           first_idx;
    logic [135:0] cur_q [$];
    logic [135:0] ref_q [$];

    function automatic logic [135:0] obs_s();
        return {bus.S1, bus.S2, bus.S3, bus.S4, bus.S5, bus.S6, bus.S7, bus.S8, bus.S9,
                bus.S10, bus.S11, bus.S12, bus.S13, bus.S14, bus.S15, bus.S16, bus.S17};
    endfunction

    task automatic model_reset();
        n     = 0;
        exp_s = '0;
    endtask

    task automatic clear_log();
        strobes   = 0;
        prog_at   = 0;
        first_idx = -1;
        cur_q.delete();
    endtask

    task automatic step(input bit v, input logic [7:0] d, input int idx);
        bus.done_i = v;
        bus.data_i = d;
        @(posedge clk);
        exp_done = 1'b0;
        exp_prog = 1'b0;
        if (v) begin
            hist[n] = d;
            if (n / COLS >= 16) begin
                // S(17-j) is the pixel j rows above the current one.
                for (int unsigned j = 0; j < 17; j++) begin
                    exp_s[j*8 +: 8] = hist[n - j*COLS];
                end
                exp_done = 1'b1;
                exp_prog = (n == NPIX - 1);
            end
            n = (n == NPIX - 1) ? 0 : n + 1;
        end
        @(negedge clk);
        check_eq("done_o", 136'(bus.done_o), 136'(exp_done));
        check_eq("progress_done_o", 136'(bus.progress_done_o), 136'(exp_prog));
        check_eq("S_vec", obs_s(), exp_s);
        if (bus.done_o) begin
            strobes++;
            cur_q.push_back(obs_s());
            if (first_idx < 0) first_idx = idx;
            if (bus.progress_done_o) prog_at = strobes;
        end
        bus.done_i = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] off, input bit gaps);
        clear_log();
        for (int i = 0; i < int'(NPIX); i++) begin
            if (gaps) begin
                while ($urandom_range(1, 0) == 1) step(1'b0, 8'($urandom), -1);
            end
            step(1'b1, 8'(i) + off, i);
        end
    endtask

    task automatic compare_to_ref(input string tag);
        check_eq({tag, "_strobes"}, 136'(cur_q.size()), 136'(ref_q.size()));
        for (int k = 0; k < ref_q.size() && k < cur_q.size(); k++) begin
            check_eq({tag, "_vec"}, cur_q[k], ref_q[k]);
        end
    endtask

    logic [135:0] v;

    initial begin
        bus.done_i = 1'b0;
        bus.data_i = '0;
        rst = 1'b1;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_done_o", 136'(bus.done_o), 136'(0));
        check_eq("rst_prog", 136'(bus.progress_done_o), 136'(0));
        check_eq("rst_S", obs_s(), '0);
        rst = 1'b0;

        // Idle: nothing accepted, outputs stay at reset values.
        clear_log();
        for (int i = 0; i < 100; i++) step(1'b0, 8'($urandom), -1);
        check_eq("idle_strobes", 136'(strobes), 136'(0));

        // Continuous frame.
        run_frame(8'd0, 1'b0);
        check_eq("c_strobes", 136'(strobes), 136'(57));
        check_eq("c_first_idx", 136'(first_idx), 136'(304));
        check_eq("c_prog_at", 136'(prog_at), 136'(57));
        if (cur_q.size() == 57) begin
            v = cur_q[0];
            check_eq("c_first_S1", 136'(v[135:128]), 136'(0));
            check_eq("c_first_S9", 136'(v[71:64]), 136'(152));
            check_eq("c_first_S17", 136'(v[7:0]), 136'(48));
            v = cur_q[56];
            check_eq("c_last_S1", 136'(v[135:128]), 136'(56));
            check_eq("c_last_S9", 136'(v[71:64]), 136'(208));
            check_eq("c_last_S17", 136'(v[7:0]), 136'(104));
        end
        ref_q = cur_q;

        // Same frame with random gaps; the final pixel is followed directly by the next frame.
        run_frame(8'd0, 1'b1);
        compare_to_ref("gap");
        check_eq("gap_prog_at", 136'(prog_at), 136'(57));

        // Back-to-back frame, data offset by one.
        run_frame(8'd1, 1'b0);
        check_eq("b2b_strobes", 136'(strobes), 136'(57));
        check_eq("b2b_first_idx", 136'(first_idx), 136'(304));
        if (cur_q.size() > 0) begin
            v = cur_q[0];
            check_eq("b2b_first_S1", 136'(v[135:128]), 136'(1));
            check_eq("b2b_first_S17", 136'(v[7:0]), 136'(49));
        end

        // Reset mid-frame: outputs clear without waiting for a clock edge.
        clear_log();
        for (int i = 0; i < 200; i++) step(1'b1, 8'($urandom), i);
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_S", obs_s(), '0);
        check_eq("mid_rst_done_o", 136'(bus.done_o), 136'(0));
        check_eq("mid_rst_prog", 136'(bus.progress_done_o), 136'(0));
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_frame(8'd0, 1'b0);
        compare_to_ref("post_rst");
        check_eq("post_rst_prog_at", 136'(prog_at), 136'(57));

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
